// File: rtl/phase_sequencer_pkg.sv
// Shared types and default sizing for the N-phase sequencer.
// Optional build macro PHASE_SEQUENCER_SKIP_EN adds a per-phase skip mask.
package phase_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int NUM_PHASES_DEF = 4;
    localparam int DWELL_W_DEF    = 8;

endpackage

// File: rtl/phase_sequencer_next.sv
// Combinational next-phase picker: chooses the phase to enter from IDLE or after a phase end.
// With PHASE_SEQUENCER_SKIP_EN defined, masked phases are stepped over.
module phase_sequencer_next
    import phase_sequencer_pkg::*;
#(
    parameter  int NUM_PHASES = NUM_PHASES_DEF,
    localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
    input  logic [PHASE_W-1:0]    cur_idx,
    input  logic                  is_idle,
    input  logic                  loop_en,
`ifdef PHASE_SEQUENCER_SKIP_EN
    input  logic [NUM_PHASES-1:0] phase_mask,
`endif
    output logic [PHASE_W-1:0]    next_idx,
    output logic                  wrap,
    output logic                  finish,
    output logic                  all_masked
);

`ifdef PHASE_SEQUENCER_SKIP_EN
    // Candidates: unmasked phases strictly above the current one (any unmasked phase from IDLE).
    logic [NUM_PHASES-1:0] above;
    logic [PHASE_W-1:0]    lowest_any;
    logic [PHASE_W-1:0]    lowest_above;
    logic                  found_above;

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_cand
            assign above[gi] = !phase_mask[gi] && (is_idle || (PHASE_W'(gi) > cur_idx));
        end
    endgenerate

    always_comb begin
        lowest_any   = '0;
        lowest_above = '0;
        found_above  = 1'b0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (!phase_mask[i]) begin
                lowest_any = PHASE_W'(i);
            end
            if (above[i]) begin
                lowest_above = PHASE_W'(i);
                found_above  = 1'b1;
            end
        end
    end

    assign all_masked = &phase_mask;
    assign next_idx   = found_above ? lowest_above : lowest_any;
    // A fully masked vector leaves nothing to wrap onto, so the pass finishes.
    assign wrap       = !found_above && loop_en && !all_masked;
    assign finish     = !found_above && (!loop_en || all_masked);
`else
    logic last;

    assign last       = (cur_idx == PHASE_W'(NUM_PHASES - 1));
    assign all_masked = 1'b0;
    assign next_idx   = (is_idle || last) ? '0 : cur_idx + 1'b1;
    assign wrap       = !is_idle && last && loop_en;
    assign finish     = !is_idle && last && !loop_en;
`endif

endmodule

// File: rtl/phase_sequencer.sv
// N-phase sequencer with per-phase dwell, hold, abort, loop mode, entry strobe and done pulse.
// Build macro PHASE_SEQUENCER_SKIP_EN adds the phase_mask input for skipping phases.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter  int NUM_PHASES = NUM_PHASES_DEF,
    parameter  int DWELL_W    = DWELL_W_DEF,
    localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          hold,
    input  logic                          loop_en,
    input  logic [NUM_PHASES*DWELL_W-1:0] dwell_cfg,
`ifdef PHASE_SEQUENCER_SKIP_EN
    input  logic [NUM_PHASES-1:0]         phase_mask,
`endif
    output logic [PHASE_W-1:0]            phase_out,
    output logic                          busy,
    output logic                          phase_strobe,
    output logic                          done
);

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;

    logic [DWELL_W-1:0]   dwell_arr [NUM_PHASES];
    logic [PHASE_W-1:0]   pick_next;
    logic                 pick_wrap;
    logic                 pick_finish;
    logic                 pick_none;

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_dwell
            assign dwell_arr[gi] = dwell_cfg[gi*DWELL_W +: DWELL_W];
        end
    endgenerate

    phase_sequencer_next #(
        .NUM_PHASES (NUM_PHASES)
    ) u_next (
        .cur_idx    (phase_q),
        .is_idle    (state_q == IDLE),
        .loop_en    (loop_en),
`ifdef PHASE_SEQUENCER_SKIP_EN
        .phase_mask (phase_mask),
`endif
        .next_idx   (pick_next),
        .wrap       (pick_wrap),
        .finish     (pick_finish),
        .all_masked (pick_none)
    );

    // Dwell for the entering phase is captured on the entry edge, so later
    // dwell_cfg edits only affect future entries.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (start && !abort && !pick_none) begin
                    state_d  = RUN;
                    phase_d  = pick_next;
                    cnt_d    = dwell_arr[pick_next];
                    strobe_d = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                    cnt_d   = '0;
                end else if (hold) begin
                    state_d = RUN;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pick_wrap || !pick_finish) begin
                    phase_d  = pick_next;
                    cnt_d    = dwell_arr[pick_next];
                    strobe_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    phase_d = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign phase_out    = phase_q;
    assign busy         = busy_q;
    assign phase_strobe = strobe_q;
    assign done         = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with hand-computed expected sequences.
// The skip-mask section is compiled only when PHASE_SEQUENCER_SKIP_EN is defined.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        hold;
    logic        loop_en;
    logic [31:0] dwell_cfg;
    logic [1:0]  phase_out;
    logic        busy;
    logic        phase_strobe;
    logic        done;
`ifdef PHASE_SEQUENCER_SKIP_EN
    logic [3:0]  phase_mask;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    phase_sequencer #(
        .NUM_PHASES (4),
        .DWELL_W    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .hold         (hold),
        .loop_en      (loop_en),
        .dwell_cfg    (dwell_cfg),
`ifdef PHASE_SEQUENCER_SKIP_EN
        .phase_mask   (phase_mask),
`endif
        .phase_out    (phase_out),
        .busy         (busy),
        .phase_strobe (phase_strobe),
        .done         (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ph, input logic bz,
                           input logic st, input logic dn);
        chk({tag, "_phase"}, phase_out, ph);
        chk({tag, "_busy"}, busy, bz);
        chk({tag, "_strobe"}, phase_strobe, st);
        chk({tag, "_done"}, done, dn);
    endtask

    // Starts a run, then checks n cycles; nibble k of ph / bit k of st is cycle t+k.
    task automatic run_seq(input string tag, input logic [31:0] dw, input int n,
                           input logic [63:0] ph, input logic [15:0] st,
                           input int hlo, input int hhi);
        dwell_cfg = dw;
        start     = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick();
            start = 1'b0;
            chk_out($sformatf("%s_t%0d", tag, k), ph[k*4 +: 2], (k < n), st[k], (k == n));
            hold = (k >= hlo) && (k <= hhi);
        end
        hold = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        hold      = 1'b0;
        loop_en   = 1'b0;
        dwell_cfg = '0;
`ifdef PHASE_SEQUENCER_SKIP_EN
        phase_mask = '0;
`endif
        tick();
        tick();
        chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // All dwells zero: 0,1,2,3 then done.
        run_seq("zero", 32'h0, 5, 64'h32100, 16'h001E, 0, -1);
        tick();
        chk_out("post_done", 2'd0, 1'b0, 1'b0, 1'b0);

        // dwell {2,0,1,0}, without and with a 3-cycle hold in phase 1.
        run_seq("dwell", 32'h0001_0002, 8, 64'h32210000, 16'h00B2, 0, -1);
        run_seq("hold", 32'h0001_0002, 11, 64'h32211110000, 16'h0512, 4, 6);

        // Abort during phase 2, then start+abort together in IDLE.
        dwell_cfg = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_pre_phase", phase_out, 2'd2);
        abort = 1'b1;
        tick();
        chk_out("abort", 2'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        chk_out("start_abort", 2'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b0;

        // Hold is ignored in IDLE; then reset in phase 1.
        hold  = 1'b1;
        start = 1'b1;
        tick();
        chk_out("hold_idle", 2'd0, 1'b1, 1'b1, 1'b0);
        hold  = 1'b0;
        start = 1'b0;
        tick();
        chk("reset_pre_phase", phase_out, 2'd1);
        reset = 1'b1;
        tick();
        chk_out("reset_mid", 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // start held during RUN does not retrigger; dwell edit after entry is not seen.
        dwell_cfg = 32'h0000_0003;
        start = 1'b1;
        tick();
        chk_out("retrig_t1", 2'd0, 1'b1, 1'b1, 1'b0);
        dwell_cfg = 32'h0;
        tick();
        chk_out("retrig_t2", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("retrig_t3", 2'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        tick();
        chk_out("retrig_t4", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("retrig_t5", 2'd1, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("retrig_abort_busy", busy, 1'b0);

        // Loop mode, cleared during the second pass's phase 1.
        loop_en = 1'b1;
        start   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            start = 1'b0;
            chk_out($sformatf("loop_t%0d", k), 2'((k - 1) % 4), 1'b1, 1'b1, 1'b0);
            if (k == 6) loop_en = 1'b0;
        end
        tick();
        chk_out("loop_done", 2'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        chk_out("restart_on_done", 2'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("restart_abort_busy", busy, 1'b0);

`ifdef PHASE_SEQUENCER_SKIP_EN
        phase_mask = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("skip_t1", 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("skip_t2", 2'd3, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("skip_t3", 2'd0, 1'b0, 1'b0, 1'b1);
        phase_mask = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("skip_all", 2'd0, 1'b0, 1'b0, 1'b0);
        phase_mask = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised N-phase sequencer, successor to the fixed 2-bit four-state sequencer. On start it walks phases 0..NUM_PHASES-1, holding each phase for a programmable dwell time. Adds hold, abort, loop mode, a per-phase entry strobe and a completion pulse. Sits beside the control FSMs and drives phase-indexed datapath enables.

Parameters:
NUM_PHASES, 4, number of phases (>=2)
DWELL_W, 8, width of each per-phase dwell field
PHASE_W, $clog2(NUM_PHASES), phase index width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request sequence start; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE
hold  in  1  freeze dwell counter and phase while RUN
loop_en  in  1  after last phase, wrap to phase 0 instead of finishing
dwell_cfg  in  NUM_PHASES*DWELL_W  field i = dwell for phase i (field i at bits [i*DWELL_W +: DWELL_W])
phase_out  out  PHASE_W  current phase index; 0 in IDLE
busy  out  1  high while RUN
phase_strobe  out  1  one-cycle pulse on the first cycle of every phase entry
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- All outputs are registered. On reset: state=IDLE, phase_out=0, busy=0, phase_strobe=0, done=0, dwell counter=0.
- Reset takes effect at the next edge, including mid-run. It has priority over everything.
- FSM states are IDLE and RUN.
- IDLE, start=1, abort=0 sampled at edge t: from t+1, state=RUN, busy=1, phase_out=0, phase_strobe=1. Counter loads dwell field 0.
- Dwell field latch: the field for an entering phase is sampled in the cycle before entry. Later dwell_cfg changes do not affect the current phase.
- RUN, hold=0:
  - If counter!=0, decrement.
  - If counter==0, the phase ends. Phase i therefore lasts dwell_i+1 cycles (excluding hold cycles).
- Phase end, not last phase: phase_out+1, strobe, load the next dwell field.
- Phase end, last phase, loop_en=1: phase_out=0, strobe, load field 0.
- Phase end, last phase, loop_en=0: next cycle IDLE, busy=0, phase_out=0, done=1 for one cycle.
- loop_en is sampled only at the last-phase exit.
- RUN, hold=1: counter and phase frozen, no strobe. Hold has no effect in IDLE.
- abort=1: next cycle IDLE, phase_out=0, busy=0, no done.
  - abort beats hold and phase advance.
  - abort with start in IDLE: start ignored.
- start while RUN: ignored; it does not retrigger.
- phase_strobe and done never assert in the same cycle.
- done and a new start may coincide: start sampled in the done cycle (state already IDLE) is accepted.

Optional Feature:
PHASE_SEQUENCER_SKIP_EN:
- Defined: adds input phase_mask [NUM_PHASES]; bit=1 skips that phase.
  - Entry and every advance go to the lowest unmasked index greater than current. Start enters the lowest unmasked index.
  - If no unmasked index is greater than current, apply the last-phase rule (wrap to lowest unmasked index, or finish).
  - Mask is sampled at each transition.
  - All bits set: start ignored, stays IDLE.
- Undefined: no port; every phase is executed.

Decomposition:
- Package phase_sequencer_pkg: typedef enum of states {IDLE, RUN}; default constants NUM_PHASES_DEF=4, DWELL_W_DEF=8.
- Sub-module phase_sequencer_next: combinational next-phase picker. Takes current index, is_idle, loop_en and optional mask. Returns next index, wrap and finish flags. Isolates skip logic behind the macro.

Test Plan:
- dwell={0,0,0,0}, loop_en=0, start at t -> phase_out 0,1,2,3 at t+1..t+4, strobe each cycle; done=1 and busy=0 at t+5.
- dwell={2,0,1,0}, start at t -> phase0 t+1..t+3, phase1 t+4, phase2 t+5..t+6, phase3 t+7; done at t+8.
- Same config, hold=1 for 3 cycles at t+4 -> phase1 spans t+4..t+7, no extra strobe, done at t+11.
- abort in phase 2 -> next cycle IDLE, phase_out=0, busy=0, done=0. Start+abort together in IDLE -> stays IDLE. reset in phase 1 -> IDLE at the next edge.
- loop_en=1, dwell all 0 -> sequence 0,1,2,3,0,1...; clear loop_en during phase 1 -> ends after phase 3 with done.
- SKIP_EN, mask=4'b0101 -> sequence 1,3, then done. mask=4'b1111 -> start ignored, busy stays 0.
